// File: rtl/npc_pkg.sv
// Shared definitions for the writeback stage and its load-alignment helper.
// Holds the datapath width, the RISC-V load funct3 encodings and the layout
// of one entry in the outstanding-load queue.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Everything needed to finish a load once its data word comes back.
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lq_entry_t;

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction.
// Picks the byte or halfword addressed by addr_lo out of an aligned memory
// word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata   - raw aligned memory word
//   funct3  - load type (lb, lh, lw, lbu, lhu; anything else returns the word)
//   addr_lo - low two bits of the effective address
//   result  - extracted, extended value
module load_align #(
    parameter int XLEN = npc_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] result
);
    import npc_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte lane and halfword; halfwords ignore
    // addr_lo[0], so misaligned halfword addresses round down.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected piece; lw and undefined encodings pass the word.
    always_comb begin
        result = rdata;
        case (funct3)
            LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
            LHU: result = {{(XLEN-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage feeding the GPR register file.
// Merges single-cycle ALU results with in-order load responses, aligns and
// extends load data, and tracks outstanding loads so decode can stall on
// registers that still have a write coming.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   iss_valid/ready, iss_rd,
//   iss_funct3, iss_addr_lo        - load issue from decode into the queue
//   alu_valid/ready, alu_rd, alu_data - ALU result handshake
//   lsu_rvalid/rready, lsu_rdata   - in-order load response from the LSU
//   rs1, rs2, rs1_busy, rs2_busy   - hazard queries from decode
//   rf_wen, rf_waddr, rf_wdata     - register file write port
module wb_stage #(
    parameter int XLEN     = npc_pkg::XLEN,
    parameter int LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [4:0]      iss_rd,
    input  logic [2:0]      iss_funct3,
    input  logic [1:0]      iss_addr_lo,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_rvalid,
    output logic            lsu_rready,
    input  logic [XLEN-1:0] lsu_rdata,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);
    import npc_pkg::*;

    localparam int              PTR_W = $clog2(LQ_DEPTH);
    localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(LQ_DEPTH);

    lq_entry_t            lq_mem [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]  lq_valid;
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count;

    lq_entry_t            head_entry;
    logic [XLEN-1:0]      load_result;
    logic                 push;
    logic                 pop;
    logic                 alu_take;
    logic                 rs1_hit;
    logic                 rs2_hit;

    // Handshakes: fullness is judged on the current count only, so a pop in
    // the same cycle never makes room for a push. Load responses win over
    // the ALU whenever they can actually be accepted.
    assign iss_ready  = (count != FULL);
    assign lsu_rready = (count != '0);
    assign alu_ready  = !(lsu_rvalid && (count != '0));
    assign push       = iss_valid && iss_ready;
    assign pop        = lsu_rvalid && lsu_rready;
    assign alu_take   = alu_valid && alu_ready;
    assign head_entry = lq_mem[head];

    load_align #(.XLEN(XLEN)) u_align (
        .rdata   (lsu_rdata),
        .funct3  (head_entry.funct3),
        .addr_lo (head_entry.addr_lo),
        .result  (load_result)
    );

    // Load queue bookkeeping. A per-slot valid bit mirrors occupancy so the
    // hazard check can scan slots without doing pointer arithmetic. Push and
    // pop never hit the same slot: both at once needs 0 < count < depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            lq_valid <= '0;
        end else begin
            if (push) begin
                lq_mem[tail]   <= '{rd: iss_rd, funct3: iss_funct3, addr_lo: iss_addr_lo};
                lq_valid[tail] <= 1'b1;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                lq_valid[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Writeback register. Loads take precedence; x0 destinations still
    // retire the load but never raise wen. Address and data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pop) begin
            rf_wen   <= (head_entry.rd != 5'd0);
            rf_waddr <= head_entry.rd;
            rf_wdata <= load_result;
        end else if (alu_take) begin
            rf_wen   <= (alu_rd != 5'd0);
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // Scan every occupied queue slot for a destination matching each query.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (lq_valid[i] && (lq_mem[i].rd == rs1)) rs1_hit = 1'b1;
            if (lq_valid[i] && (lq_mem[i].rd == rs2)) rs2_hit = 1'b1;
        end
    end

    // A register stays busy until its last pending write has landed on the
    // register file port, covering the cycle the write is in flight.
    assign rs1_busy = (rs1 != 5'd0) && (rs1_hit || (rf_wen && (rf_waddr == rs1)));
    assign rs2_busy = (rs2 != 5'd0) && (rs2_hit || (rf_wen && (rf_waddr == rs2)));

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [2:0]  iss_funct3;
    logic [1:0]  iss_addr_lo;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] lsu_rdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] alo;
    } ent_t;

    ent_t        mq[$];
    logic        mWen;
    logic [4:0]  mWaddr;
    logic [31:0] mWdata;

    int checkCount = 0;
    int passCount  = 0;

    wb_stage #(.XLEN(32), .LQ_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rd      (iss_rd),
        .iss_funct3  (iss_funct3),
        .iss_addr_lo (iss_addr_lo),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_rvalid  (lsu_rvalid),
        .lsu_rready  (lsu_rready),
        .lsu_rdata   (lsu_rdata),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Reference load extraction using plain shifts and masks.
    function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic modelBusy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (mWen && mWaddr == r) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs at the falling edge, compare every output
    // with the model, then advance the model across the next rising edge.
    task automatic applyStimulus(input logic rstn, input logic iv, input logic [4:0] ird,
                                 input logic [2:0] if3, input logic [1:0] ia,
                                 input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic lv, input logic [31:0] ld,
                                 input logic [4:0] r1, input logic [4:0] r2);
        logic expIssRdy;
        logic expLsuRdy;
        logic expAluRdy;
        ent_t e;
        @(negedge clk);
        rst_n = rstn; iss_valid = iv; iss_rd = ird; iss_funct3 = if3; iss_addr_lo = ia;
        alu_valid = av; alu_rd = ard; alu_data = ad; lsu_rvalid = lv; lsu_rdata = ld;
        rs1 = r1; rs2 = r2;
        #1;
        expIssRdy = (mq.size() != DEPTH);
        expLsuRdy = (mq.size() != 0);
        expAluRdy = !(lv && mq.size() != 0);
        checkOutput("iss_ready",  32'(iss_ready),  32'(expIssRdy));
        checkOutput("lsu_rready", 32'(lsu_rready), 32'(expLsuRdy));
        checkOutput("alu_ready",  32'(alu_ready),  32'(expAluRdy));
        checkOutput("rs1_busy",   32'(rs1_busy),   32'(modelBusy(r1)));
        checkOutput("rs2_busy",   32'(rs2_busy),   32'(modelBusy(r2)));
        checkOutput("rf_wen",     32'(rf_wen),     32'(mWen));
        checkOutput("rf_waddr",   32'(rf_waddr),   32'(mWaddr));
        checkOutput("rf_wdata",   rf_wdata,        mWdata);
        if (!rstn) begin
            mq.delete();
            mWen = 1'b0; mWaddr = '0; mWdata = '0;
        end else begin
            if (lv && expLsuRdy) begin
                e = mq.pop_front();
                mWen = (e.rd != 0); mWaddr = e.rd; mWdata = modelLoad(ld, e.f3, e.alo);
            end else if (av && expAluRdy) begin
                mWen = (ard != 0); mWaddr = ard; mWdata = ad;
            end else begin
                mWen = 1'b0;
            end
            if (iv && expIssRdy) mq.push_back('{rd: ird, f3: if3, alo: ia});
        end
        @(posedge clk);
    endtask

    task automatic idleCycle(input logic [4:0] r1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    // Check the write that landed at the edge just passed against constants.
    task automatic expectWrite(input string tag, input logic wen, input logic [4:0] addr, input logic [31:0] data);
        #1;
        checkOutput({tag, "_wen"},   32'(rf_wen),   32'(wen));
        checkOutput({tag, "_waddr"}, 32'(rf_waddr), 32'(addr));
        checkOutput({tag, "_wdata"}, rf_wdata,      data);
    endtask

    initial begin
        rst_n = 0; iss_valid = 0; iss_rd = 0; iss_funct3 = 0; iss_addr_lo = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0; lsu_rvalid = 0; lsu_rdata = 0;
        rs1 = 0; rs2 = 0;
        mWen = 0; mWaddr = 0; mWdata = 0;
        repeat (2) @(posedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 0);
        expectWrite("alu", 1, 5, 32'h1234);

        applyStimulus(1, 1, 3, 3'b000, 2, 0, 0, 0, 0, 0, 3, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0080FF00, 3, 0);
        expectWrite("lb", 1, 3, 32'hFFFFFF80);
        applyStimulus(1, 1, 3, 3'b100, 2, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0080FF00, 0, 0);
        expectWrite("lbu", 1, 3, 32'h00000080);
        applyStimulus(1, 1, 3, 3'b001, 3, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80001234, 0, 0);
        expectWrite("lh", 1, 3, 32'hFFFF8000);

        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 1, 5'(i), 3'b010, 0, 0, 0, 0, 0, 0, 2, 4);
        #1;
        checkOutput("full_iss_ready", 32'(iss_ready), 32'd0);
        applyStimulus(1, 1, 9, 3'b010, 0, 0, 0, 0, 0, 0, 2, 4);
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100 + 32'(i), 2, 4);
        idleCycle(2);
        idleCycle(2);

        applyStimulus(1, 1, 9, 3'b010, 0, 0, 0, 0, 0, 0, 7, 9);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 32'hA5A5, 1, 32'h5555, 7, 9);
        expectWrite("prio_load", 1, 9, 32'h5555);
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 32'hA5A5, 0, 0, 7, 9);
        expectWrite("prio_alu", 1, 7, 32'hA5A5);

        applyStimulus(1, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        expectWrite("x0", 0, 0, 32'hDEADBEEF);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0);
        expectWrite("empty_resp", 0, 0, 32'hDEADBEEF);

        applyStimulus(1, 1, 6, 3'b010, 0, 0, 0, 0, 0, 0, 6, 8);
        applyStimulus(1, 1, 8, 3'b010, 0, 0, 0, 0, 0, 0, 6, 8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 8);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 6, 8);

        for (int n = 0; n < 3000; n++) begin
            logic rstn;
            int   phase;
            phase = (n / 300) % 3;
            rstn  = ($urandom_range(0, 199) != 0);
            applyStimulus(rstn,
                          ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 3 : 5))),
                          5'($urandom_range(0, 7)), 3'($urandom), 2'($urandom),
                          1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < (phase == 0 ? 3 : (phase == 1 ? 8 : 5))),
                          $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
